// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// Holds the memory-access FSM state encoding and the hardwired zero register index.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of hazard inputs, memory handshake and stage-control outputs of the sequencer.
// master = the sequencer itself, slave = the pipeline datapath / data memory side.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       IF_ID_Rs_i;
    logic [4:0]       IF_ID_Rt_i;
    logic [4:0]       ID_EX_Rt_i;
    logic             ID_EX_MemRd_i;
    logic             branch_taken_i;
    logic             EX_MEM_MemRd_i;
    logic             EX_MEM_MemWr_i;
    logic             mem_ack_i;
    logic             PC_write_o;
    logic             IF_ID_write_o;
    logic             IF_ID_flush_o;
    logic             ID_EX_bubble_o;
    logic             pipe_stall_o;
    logic             mem_req_o;
    logic             mem_err_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        input  IF_ID_Rs_i, IF_ID_Rt_i, ID_EX_Rt_i, ID_EX_MemRd_i, branch_taken_i,
        input  EX_MEM_MemRd_i, EX_MEM_MemWr_i, mem_ack_i,
        output PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o,
        output pipe_stall_o, mem_req_o, mem_err_o, stall_cnt_o
    );

    modport slave (
        output IF_ID_Rs_i, IF_ID_Rt_i, ID_EX_Rt_i, ID_EX_MemRd_i, branch_taken_i,
        output EX_MEM_MemRd_i, EX_MEM_MemWr_i, mem_ack_i,
        input  PC_write_o, IF_ID_write_o, IF_ID_flush_o, ID_EX_bubble_o,
        input  pipe_stall_o, mem_req_o, mem_err_o, stall_cnt_o
    );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use detector: a load in EX whose destination feeds an operand of the instruction in ID.
// Writes to register 0 never create a dependency.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       i_id_ex_memrd,
    input  logic [4:0] i_id_ex_rt,
    input  logic [4:0] i_if_id_rs,
    input  logic [4:0] i_if_id_rt,
    output logic       o_load_use
);

    // Compare the pending load destination against both ID source fields
    always_comb begin
        o_load_use = i_id_ex_memrd && (i_id_ex_rt != REG_ZERO) &&
                     ((i_id_ex_rt == i_if_id_rs) || (i_id_ex_rt == i_if_id_rt));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory-access freeze FSM, load-use bubbles,
// branch flushes, sticky timeout error and a saturating stall-cycle counter.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    pipeline_ctrl_if.master bus
);

    localparam int                WAIT_W      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_ZERO   = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0] WAIT_ONE    = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] WAIT_LIMIT  = MEM_TIMEOUT[WAIT_W-1:0];
    localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

    state_e            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_err;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_memop;
    logic w_load_use;
    logic w_fsm_stall;
    logic w_stall;
    logic w_lu_stall;
    logic w_pc_write;
    logic w_ifid_write;
    logic w_ifid_flush;
    logic w_idex_bubble;

    hazard_detect u_hazard_detect (
        .i_id_ex_memrd (bus.ID_EX_MemRd_i),
        .i_id_ex_rt    (bus.ID_EX_Rt_i),
        .i_if_id_rs    (bus.IF_ID_Rs_i),
        .i_if_id_rt    (bus.IF_ID_Rt_i),
        .o_load_use    (w_load_use)
    );

    // Freeze request: a fresh memop in IDLE or an outstanding access; MEM_DONE always releases
    always_comb begin
        w_memop     = bus.EX_MEM_MemRd_i | bus.EX_MEM_MemWr_i;
        w_fsm_stall = 1'b0;
        case (r_state)
            IDLE:     w_fsm_stall = w_memop;
            MEM_WAIT: w_fsm_stall = 1'b1;
            MEM_DONE: w_fsm_stall = 1'b0;
            default:  w_fsm_stall = 1'b0;
        endcase
    end

    // Priority: reset, global freeze, load-use bubble, taken-branch flush, free-running
    always_comb begin
        w_pc_write    = 1'b1;
        w_ifid_write  = 1'b1;
        w_ifid_flush  = 1'b0;
        w_idex_bubble = 1'b0;
        w_stall       = 1'b0;
        w_lu_stall    = 1'b0;
        if (!rst_i) begin
            w_stall = 1'b0;
        end else if (w_fsm_stall) begin
            w_stall      = 1'b1;
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
        end else if (w_load_use) begin
            w_lu_stall    = 1'b1;
            w_pc_write    = 1'b0;
            w_ifid_write  = 1'b0;
            w_idex_bubble = 1'b1;
        end else if (bus.branch_taken_i) begin
            w_ifid_flush = 1'b1;
        end else begin
            w_ifid_flush = 1'b0;
        end
    end

    // Memory-access FSM with timeout watchdog and sticky error flag
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state    <= IDLE;
            r_wait_cnt <= WAIT_ZERO;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_memop && bus.mem_ack_i) begin
                        r_state <= MEM_DONE;
                    end else if (w_memop) begin
                        r_state    <= MEM_WAIT;
                        r_wait_cnt <= WAIT_ONE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_ack_i) begin
                        r_state    <= MEM_DONE;
                        r_wait_cnt <= WAIT_ZERO;
                    end else if (r_wait_cnt == WAIT_LIMIT) begin
                        r_state    <= MEM_DONE;
                        r_wait_cnt <= WAIT_ZERO;
                        r_mem_err  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_ONE;
                    end
                end
                MEM_DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state    <= IDLE;
                    r_wait_cnt <= WAIT_ZERO;
                end
            endcase
        end
    end

    // Saturating count of frozen or bubbled cycles
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_stall_cnt <= CNT_ZERO;
        end else if ((w_stall || w_lu_stall) && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign bus.PC_write_o     = w_pc_write;
    assign bus.IF_ID_write_o  = w_ifid_write;
    assign bus.IF_ID_flush_o  = w_ifid_flush;
    assign bus.ID_EX_bubble_o = w_idex_bubble;
    assign bus.pipe_stall_o   = w_stall;
    assign bus.mem_req_o      = w_stall;
    assign bus.mem_err_o      = r_mem_err;
    assign bus.stall_cnt_o    = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the stall/flush rules.
module tb_pipeline_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CW      = 8;
    localparam int CMAX    = (1 << CW) - 1;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    // model state
    bit m_busy;
    bit m_release;
    int m_waited;
    bit m_err;
    int m_cnt;

    pipeline_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_ctrl #(.MEM_TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.IF_ID_Rs_i     = 5'd0;
        bus.IF_ID_Rt_i     = 5'd0;
        bus.ID_EX_Rt_i     = 5'd0;
        bus.ID_EX_MemRd_i  = 1'b0;
        bus.branch_taken_i = 1'b0;
        bus.EX_MEM_MemRd_i = 1'b0;
        bus.EX_MEM_MemWr_i = 1'b0;
        bus.mem_ack_i      = 1'b0;
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model over the edge
    task automatic cycle();
        bit memop, hazard, e_stall, e_lu, e_pc, e_ifw, e_flush, e_bub;
        #4;
        memop  = bus.EX_MEM_MemRd_i || bus.EX_MEM_MemWr_i;
        hazard = bus.ID_EX_MemRd_i && (bus.ID_EX_Rt_i != 5'd0) &&
                 (bus.ID_EX_Rt_i == bus.IF_ID_Rs_i || bus.ID_EX_Rt_i == bus.IF_ID_Rt_i);
        if (!rst) begin
            e_stall = 1'b0; e_lu = 1'b0; e_pc = 1'b1; e_ifw = 1'b1; e_flush = 1'b0; e_bub = 1'b0;
        end else begin
            e_stall = !m_release && (m_busy || memop);
            e_lu    = !e_stall && hazard;
            e_pc    = !e_stall && !e_lu;
            e_ifw   = e_pc;
            e_bub   = e_lu;
            e_flush = !e_stall && !e_lu && bus.branch_taken_i;
        end
        check_eq("pc_write",   32'(bus.PC_write_o),     32'(e_pc));
        check_eq("ifid_write", 32'(bus.IF_ID_write_o),  32'(e_ifw));
        check_eq("ifid_flush", 32'(bus.IF_ID_flush_o),  32'(e_flush));
        check_eq("idex_bubble",32'(bus.ID_EX_bubble_o), 32'(e_bub));
        check_eq("pipe_stall", 32'(bus.pipe_stall_o),   32'(e_stall));
        check_eq("mem_req",    32'(bus.mem_req_o),      32'(e_stall));
        check_eq("mem_err",    32'(bus.mem_err_o),      32'(m_err));
        check_eq("stall_cnt",  32'(bus.stall_cnt_o),    32'(m_cnt));
        if (!rst) begin
            m_busy = 1'b0; m_release = 1'b0; m_waited = 0; m_err = 1'b0; m_cnt = 0;
        end else begin
            if ((e_stall || e_lu) && m_cnt < CMAX) m_cnt++;
            if (m_release) begin
                m_release = 1'b0;
            end else if (m_busy) begin
                if (bus.mem_ack_i) begin
                    m_busy = 1'b0; m_release = 1'b1;
                end else if (m_waited == TIMEOUT) begin
                    m_busy = 1'b0; m_release = 1'b1; m_err = 1'b1;
                end else begin
                    m_waited++;
                end
            end else if (memop) begin
                if (bus.mem_ack_i) m_release = 1'b1;
                else begin
                    m_busy = 1'b1; m_waited = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_busy = 1'b0; m_release = 1'b0; m_waited = 0; m_err = 1'b0; m_cnt = 0;
        clear_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: reset held with a load in MEM
        bus.EX_MEM_MemRd_i = 1'b1;
        repeat (2) cycle();
        check_eq("t1_cnt", 32'(bus.stall_cnt_o), 32'd0);

        // 2: load acknowledged on its third cycle
        rst = 1'b1;
        cycle();
        cycle();
        bus.mem_ack_i = 1'b1;
        cycle();
        clear_inputs();
        cycle();
        cycle();
        check_eq("t2_cnt", 32'(bus.stall_cnt_o), 32'd3);

        // 3: load-use on rs, then the same with rt=0
        bus.ID_EX_MemRd_i = 1'b1;
        bus.ID_EX_Rt_i    = 5'd5;
        bus.IF_ID_Rs_i    = 5'd5;
        #4;
        check_eq("t3_bubble", 32'(bus.ID_EX_bubble_o), 32'd1);
        #(-0);
        @(posedge clk);
        #1;
        m_cnt++;
        bus.ID_EX_Rt_i = 5'd0;
        bus.IF_ID_Rs_i = 5'd0;
        cycle();

        // 4: branch under load-use is deferred, then flushes
        bus.ID_EX_Rt_i     = 5'd7;
        bus.IF_ID_Rt_i     = 5'd7;
        bus.branch_taken_i = 1'b1;
        cycle();
        bus.ID_EX_MemRd_i = 1'b0;
        cycle();
        clear_inputs();

        // 5: store that never completes times out
        bus.EX_MEM_MemWr_i = 1'b1;
        repeat (5) cycle();
        check_eq("t5_err", 32'(bus.mem_err_o), 32'd1);
        bus.EX_MEM_MemWr_i = 1'b0;
        cycle();
        cycle();

        // 6: back-to-back stores acked immediately
        bus.EX_MEM_MemWr_i = 1'b1;
        bus.mem_ack_i      = 1'b1;
        repeat (4) cycle();
        clear_inputs();
        cycle();

        // 7: reset in the middle of an access
        bus.EX_MEM_MemRd_i = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        #4;
        check_eq("t7_req", 32'(bus.mem_req_o), 32'd0);
        #(-0);
        @(posedge clk);
        #1;
        m_busy = 1'b0; m_release = 1'b0; m_waited = 0; m_err = 1'b0; m_cnt = 0;
        rst = 1'b1;
        bus.EX_MEM_MemRd_i = 1'b0;
        cycle();
        check_eq("t7_err", 32'(bus.mem_err_o), 32'd0);

        // stall counter saturation with repeated timeouts
        bus.EX_MEM_MemWr_i = 1'b1;
        repeat (400) cycle();
        check_eq("sat_cnt", 32'(bus.stall_cnt_o), 32'(CMAX));
        clear_inputs();
        rst = 1'b0;
        cycle();
        rst = 1'b1;

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            rst                = ($urandom_range(0, 99) != 0);
            bus.EX_MEM_MemRd_i = ($urandom_range(0, 5) == 0);
            bus.EX_MEM_MemWr_i = ($urandom_range(0, 5) == 0);
            bus.mem_ack_i      = ($urandom_range(0, 2) == 0);
            bus.ID_EX_MemRd_i  = 1'($urandom_range(0, 1));
            bus.ID_EX_Rt_i     = 5'($urandom_range(0, 3));
            bus.IF_ID_Rs_i     = 5'($urandom_range(0, 3));
            bus.IF_ID_Rt_i     = 5'($urandom_range(0, 3));
            bus.branch_taken_i = ($urandom_range(0, 3) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
